// File: rtl/lift_window_feeder.sv
// Row feeder for the 5/3 lifting stage: symmetric-extended 4-sample windows plus p/even_odd/fwd_inv/out_last.
// Windows register on the edge that accepts the triggering sample. A stalled window blocks input (in_ready = !out_valid || out_ready).
module lift_window_feeder #(
   parameter int W       = 24,
   parameter int ROW_LEN = 256
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         fwd_inv_in,
   output logic [W-1:0] x2,
   output logic [W-1:0] x3,
   output logic [W-1:0] x4,
   output logic [W-1:0] x5,
   output logic         p,
   output logic         even_odd,
   output logic         fwd_inv,
   output logic         out_last,
   output logic         out_valid,
   input  logic         out_ready
);
   localparam int CW = $clog2(ROW_LEN);

   logic [CW-1:0] col;
   logic [W-1:0]  h1, h2, h3;
   logic          row_par;
   logic          row_dir;
   logic          take;
   logic          emit_first, emit_mid, emit_last;

   assign in_ready   = !out_valid || out_ready;
   assign take       = in_valid && in_ready;
   assign emit_first = (col == CW'(2));
   assign emit_last  = (col == CW'(ROW_LEN - 1));
   // Interior windows start at column 4; the extra bit keeps the bound valid when ROW_LEN = 4.
   assign emit_mid   = !col[0] && ((CW+1)'(col) >= (CW+1)'(4));

   always_ff @(posedge clk) begin
      if (rst) begin
         col       <= '0;
         h1        <= '0;
         h2        <= '0;
         h3        <= '0;
         row_par   <= 1'b0;
         row_dir   <= 1'b0;
         x2        <= '0;
         x3        <= '0;
         x4        <= '0;
         x5        <= '0;
         p         <= 1'b0;
         even_odd  <= 1'b0;
         fwd_inv   <= 1'b0;
         out_last  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         if (out_valid && out_ready)
            out_valid <= 1'b0;
         if (take) begin
            h1 <= in_data;
            h2 <= h1;
            h3 <= h2;
            if (emit_last) begin
               col     <= '0;
               row_par <= !row_par;
            end else begin
               col <= col + CW'(1);
            end
            if (col == '0)
               row_dir <= fwd_inv_in;
            // Flags are captured per window so the last window keeps its own row's parity.
            if (emit_first || emit_mid || emit_last) begin
               out_valid <= 1'b1;
               p         <= emit_first;
               out_last  <= emit_last;
               even_odd  <= row_par;
               fwd_inv   <= row_dir;
            end
            if (emit_first) begin
               x2 <= h1;
               x3 <= h2;
               x4 <= h1;
               x5 <= in_data;
            end else if (emit_last) begin
               x2 <= h2;
               x3 <= h1;
               x4 <= in_data;
               x5 <= h1;
            end else if (emit_mid) begin
               x2 <= h3;
               x3 <= h2;
               x4 <= h1;
               x5 <= in_data;
            end
         end
      end
   end
endmodule

// File: doc/lift_window_feeder.md
# lift_window_feeder

Upstream feeder for the `add_mul` 5/3 lifting stage of the JPEG-2000 wavelet datapath. It accepts one row of signed samples at one sample per cycle over a valid/ready handshake. It applies whole-sample symmetric extension at both row edges and emits one 4-sample window per output pair on the `x2..x5` bus that `add_mul` consumes. It also generates the `p`, `even_odd` and `fwd_inv` controls that accompany each window.

## Interface
- `W`, 24, sample width in bits, two's-complement; matches the `add_mul` operand width.
- `ROW_LEN`, 256, samples per row; must be even and ≥ 4.
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_data`  in  W  sample x[k].
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  the block accepts `in_data` this cycle.
- `fwd_inv_in`  in  1  transform direction (1 = forward); sampled with x[0] of each row.
- `x2`, `x3`, `x4`, `x5`  out  W each  window operands, registered.
- `p`  out  1  first window of the row (left-edge extension applied).
- `even_odd`  out  1  row parity; 0 on row 0.
- `fwd_inv`  out  1  direction latched for the current row.
- `out_last`  out  1  last window of the row (right-edge extension applied).
- `out_valid`  out  1  window outputs are valid.
- `out_ready`  in  1  downstream takes the window.

## Operation
- Acceptance: a sample is taken when `in_valid && in_ready`. `in_ready = !out_valid || out_ready` (single output register, no skid buffer).
- Column counter `col` runs 0..ROW_LEN-1 and advances once per accepted sample. At ROW_LEN-1 it wraps to 0 and `even_odd` toggles.
- A 3-deep history holds the last three accepted samples, h1 (newest), h2, h3.
- Window j (j = 0..ROW_LEN/2-1) is {x2,x3,x4,x5} = {x[2j-1], x[2j], x[2j+1], x[2j+2]}.
- Symmetric extension: x[-1] = x[1] and x[ROW_LEN] = x[ROW_LEN-2].
- Emission rules, where s is the sample just accepted:
  - col = 2: window 0 = {h1, h2, h1, s} = {x1, x0, x1, x2}; `p` = 1.
  - col even, 4..ROW_LEN-2: {h3, h2, h1, s}; `p` = 0.
  - col = ROW_LEN-1: {h2, h1, s, h1} = {x[N-3], x[N-2], x[N-1], x[N-2]}; `out_last` = 1.
  - All other columns load the history only and emit nothing.
- Each row yields exactly ROW_LEN/2 windows.
- `fwd_inv` is loaded from `fwd_inv_in` when col = 0 is accepted and held for the whole row. A mid-row change of `fwd_inv_in` is ignored.
- Arithmetic: none. Samples pass bit-exact with no sign extension or truncation.

## Timing
- Window outputs and flags register on the edge that accepts the triggering sample. `out_valid` is high the following cycle.
- Latency from accepting x[2] to window 0 valid is 1 cycle. Throughput is 1 sample/cycle, which gives 1 window per 2 cycles.
- If `out_valid && !out_ready`: all outputs hold, `in_ready` = 0, and no sample is accepted.
- `out_valid` drops the cycle after the handshake unless a new window is emitted on that same edge. A handshake and a new emission may occur on the same edge.
- Reset values: `out_valid`, `p`, `out_last`, `even_odd`, `fwd_inv` = 0; `x2..x5` = 0; `col` = 0; history = 0; `in_ready` = 1 in the cycle after reset.
- Reset mid-row discards the partial row and any pending window. The next accepted sample is x[0] of row 0.
- Row boundary: x[0] of the next row may be accepted the cycle after x[ROW_LEN-1], provided `in_ready` = 1. No bubble is required.

## Test plan
- ROW_LEN=4, `fwd_inv_in`=1, row 80,120,164,200 streamed with no stalls -> window {120,80,120,164} with p=1, then {120,164,200,164} with out_last=1. `even_odd`=0 and `fwd_inv`=1 on both.
- ROW_LEN=8, row 0..7 ×10 -> four windows: {10,0,10,20}, {10,20,30,40}, {30,40,50,60}, {50,60,70,60} (last has out_last=1).
- Backpressure: `out_ready` held 0 for 5 cycles with window 0 pending -> outputs stable, `in_ready`=0, no samples lost. Release gives the same window sequence.
- Three back-to-back rows (ROW_LEN=4) -> `even_odd` reads 0,1,0 per row. `fwd_inv_in` toggled at col 2 of row 1 has no effect until row 2.
- Negative samples -800000,-1,0,7FFFFF (W=24) -> windows carry the bit patterns unchanged.
- `rst` asserted after col 5 of an 8-sample row -> `out_valid`=0 the next cycle. The following row starts at col 0 with `even_odd`=0 and yields 4 correct windows.
